// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time and buffers {addr, instr} in a FIFO.
// Optional performance counters (fetch_cnt, flush_cnt) are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  address,
    input  logic               addr_valid,
    output logic               addr_ready,
    input  logic               flush,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_valid,
    input  logic               instr_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  fa_q [DEPTH];
    logic [INSTR_W-1:0] fd_q [DEPTH];
    logic               push, pop;

    assign addr_ready  = (state_q == IDLE) && !RESET && !flush && (count_q < CNT_W'(DEPTH));
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = fd_q[rd_ptr_q];
    assign instr_addr  = fa_q[rd_ptr_q];
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (addr_valid && addr_ready) begin
                    mem_addr_d = address;
                    mem_req_d  = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    push      = !flush;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The handshake cannot be aborted; wait for the ack and throw the data away.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            fa_q[wr_ptr_q] <= mem_addr_q;
            fd_q[wr_ptr_q] <= mem_rdata;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        flush_hit;

    assign flush_hit = flush && ((count_q != '0) || (state_q != IDLE));
    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pop && (fetch_cnt_q != 16'hFFFF))
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (flush_hit && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  address;
    logic        addr_valid;
    logic        addr_ready;
    logic        flush;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instr;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic        instr_ready;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_cnt, flush_cnt;
`endif

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .address(address), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instr(instr), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef IFU_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fetched entries as a queue, plus the single outstanding request.
    typedef struct packed { logic [7:0] a; logic [15:0] d; } ent_t;
    ent_t        q[$];
    bit          pend, drop;
    logic [7:0]  pend_addr;
    int          fcnt, flcnt;

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    initial begin
        int  p_av, p_ack, p_rdy, p_fl, p_rst;
        bit  exp_ready, do_pop, do_ack;
        RESET = 1'b1; addr_valid = 1'b1; address = 8'h00; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0; instr_ready = 1'b0;
        pend = 0; drop = 0; pend_addr = 8'h00; fcnt = 0; flcnt = 0;

        for (int i = 0; i < 1600; i++) begin
            if (i < 200)       begin p_av = 100; p_ack = 100; p_rdy = 100; p_fl = 0;  p_rst = 0; end
            else if (i < 450)  begin p_av = 90;  p_ack = 60;  p_rdy = 10;  p_fl = 0;  p_rst = 0; end
            else if (i < 1100) begin p_av = 70;  p_ack = 40;  p_rdy = 50;  p_fl = 10; p_rst = 2; end
            else               begin p_av = 100; p_ack = 100; p_rdy = 100; p_fl = 25; p_rst = 1; end

            @(negedge CLK);
            if (i >= 2) begin
                RESET       = rnd(p_rst);
                addr_valid  = rnd(p_av);
                address     = 8'($urandom);
                flush       = rnd(p_fl);
                mem_ack     = rnd(p_ack);
                mem_rdata   = 16'($urandom);
                instr_ready = rnd(p_rdy);
            end
            #1;
            exp_ready = !RESET && !pend && !flush && (q.size() < 4);
            chk("addr_ready", {31'd0, addr_ready}, {31'd0, exp_ready});
            if (i >= 1) begin
                chk("mem_req", {31'd0, mem_req}, {31'd0, pend});
                chk("mem_addr", {24'd0, mem_addr}, {24'd0, pend_addr});
                chk("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
                if (q.size() != 0) begin
                    chk("instr", {16'd0, instr}, {16'd0, q[0].d});
                    chk("instr_addr", {24'd0, instr_addr}, {24'd0, q[0].a});
                end
`ifdef IFU_PERF_CNT_EN
                chk("fetch_cnt", {16'd0, fetch_cnt}, fcnt);
                chk("flush_cnt", {16'd0, flush_cnt}, flcnt);
`endif
            end

            @(posedge CLK);
            if (RESET) begin
                q.delete(); pend = 0; drop = 0; pend_addr = 8'h00; fcnt = 0; flcnt = 0;
            end else begin
                do_pop = (q.size() != 0) && instr_ready;
                do_ack = pend && mem_ack;
                if (do_pop && fcnt < 16'hFFFF) fcnt++;
                if (flush && (q.size() != 0 || pend) && flcnt < 16'hFFFF) flcnt++;
                if (flush) q.delete();
                else begin
                    if (do_pop) void'(q.pop_front());
                    if (do_ack && !drop) q.push_back('{a: pend_addr, d: mem_rdata});
                end
                if (do_ack) begin pend = 0; drop = 0; end
                else if (pend && flush) drop = 1;
                if (exp_ready && addr_valid) begin pend = 1; drop = 0; pend_addr = address; end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
